// File: rtl/lc3b_ir_queue.sv
// LC-3b instruction register queue: DEPTH-entry circular buffer of fetched words
// with the head word presented as decoded fields and sign/zero-extended offsets.
module lc3b_ir_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [15:0]   in_word,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic [3:0]    opcode,
    output logic [2:0]    dest,
    output logic [2:0]    src1,
    output logic [2:0]    src2,
    output logic          imm_bit,
    output logic          jsr_bit,
    output logic [1:0]    shift_flags,
    output logic [3:0]    imm4,
    output logic [4:0]    imm5,
    output logic [7:0]    trapvect8,
    output logic [5:0]    offset6,
    output logic [8:0]    offset9,
    output logic [10:0]   offset11,
    output logic [15:0]   sext5,
    output logic [15:0]   sext6,
    output logic [15:0]   adj6,
    output logic [15:0]   adj9,
    output logic [15:0]   adj11,
    output logic [15:0]   zext8x2
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [15:0]   head;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; ready/valid come from registered state only, and flush cancels both.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is data-only: contents survive pop/flush, validity lives in count_q.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= in_word;
    end

    assign head = out_valid ? mem_q[rptr_q] : 16'h0000;

    assign opcode      = head[15:12];
    assign dest        = head[11:9];
    assign src1        = head[8:6];
    assign src2        = head[2:0];
    assign imm_bit     = head[5];
    assign jsr_bit     = head[11];
    assign shift_flags = head[5:4];
    assign imm4        = head[3:0];
    assign imm5        = head[4:0];
    assign trapvect8   = head[7:0];
    assign offset6     = head[5:0];
    assign offset9     = head[8:0];
    assign offset11    = head[10:0];
    assign sext5       = {{11{head[4]}}, head[4:0]};
    assign sext6       = {{10{head[5]}}, head[5:0]};
    assign adj6        = {{9{head[5]}}, head[5:0], 1'b0};
    assign adj9        = {{6{head[8]}}, head[8:0], 1'b0};
    assign adj11       = {{4{head[10]}}, head[10:0], 1'b0};
    assign zext8x2     = {7'b0, head[7:0], 1'b0};
endmodule

// File: tb/tb_lc3b_ir_queue.sv
// Bench for lc3b_ir_queue: directed field/boundary scenarios plus random traffic
// checked against a queue-based reference model.
module tb_lc3b_ir_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int OW    = 157;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, out_ready;
    logic [15:0] in_word;
    logic in_ready, out_valid;
    logic [CW-1:0] count;
    logic [3:0] opcode, imm4;
    logic [2:0] dest, src1, src2;
    logic imm_bit, jsr_bit;
    logic [1:0] shift_flags;
    logic [4:0] imm5;
    logic [7:0] trapvect8;
    logic [5:0] offset6;
    logic [8:0] offset9;
    logic [10:0] offset11;
    logic [15:0] sext5, sext6, adj6, adj9, adj11, zext8x2;

    logic [15:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    lc3b_ir_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .count(count),
        .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
        .imm_bit(imm_bit), .jsr_bit(jsr_bit), .shift_flags(shift_flags),
        .imm4(imm4), .imm5(imm5), .trapvect8(trapvect8),
        .offset6(offset6), .offset9(offset9), .offset11(offset11),
        .sext5(sext5), .sext6(sext6), .adj6(adj6), .adj9(adj9),
        .adj11(adj11), .zext8x2(zext8x2)
    );

    always #5 clk = ~clk;

    wire [OW-1:0] dut_outs = {out_valid, opcode, dest, src1, src2, imm_bit, jsr_bit,
                              shift_flags, imm4, imm5, trapvect8, offset6, offset9,
                              offset11, sext5, sext6, adj6, adj9, adj11, zext8x2};

    // Reference decode: signed field values computed with integer arithmetic.
    function automatic logic [OW-1:0] model_outs(input bit valid, input logic [15:0] w);
        int s5, s6, s9, s11, z8;
        if (!valid) return '0;
        s5  = int'(w[4:0])  - (w[4]  ? 32   : 0);
        s6  = int'(w[5:0])  - (w[5]  ? 64   : 0);
        s9  = int'(w[8:0])  - (w[8]  ? 512  : 0);
        s11 = int'(w[10:0]) - (w[10] ? 2048 : 0);
        z8  = int'(w[7:0]);
        return {1'b1, w[15:12], w[11:9], w[8:6], w[2:0], w[5], w[11], w[5:4], w[3:0],
                w[4:0], w[7:0], w[5:0], w[8:0], w[10:0], 16'(s5), 16'(s6),
                16'(s6 * 2), 16'(s9 * 2), 16'(s11 * 2), 16'(z8 * 2)};
    endfunction

    function automatic logic [OW-1:0] model_head();
        if (exp_q.size() == 0) return model_outs(1'b0, 16'h0);
        return model_outs(1'b1, exp_q[0]);
    endfunction

    // Drive one cycle, let the edge happen, advance the model, then settle.
    task automatic cycle(input bit iv, input logic [15:0] w, input bit ordy, input bit fl);
        bit do_push, do_pop;
        in_valid  = iv;
        in_word   = w;
        out_ready = ordy;
        flush     = fl;
        do_pop  = (exp_q.size() > 0) && ordy;
        do_push = iv && (exp_q.size() < DEPTH);
        @(posedge clk);
        if (fl) exp_q.delete();
        else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(w);
        end
        #1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = '0;
        exp_q.delete();
        #12;
        checks++;
        if (count !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d in_ready=%b out_valid=%b want 0/1/0", count, in_ready, out_valid);
        end
        checks++;
        if (dut_outs !== '0) begin
            errors++;
            $display("FAIL reset_fields: got %h want 0", dut_outs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fields();
        logic [15:0] words [5] = '{16'h1283, 16'h12BF, 16'h0FFF, 16'h4FFE, 16'hF025};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, words[i], 1'b0, 1'b0);
            checks++;
            if (dut_outs !== model_head() || count !== CW'(1)) begin
                errors++;
                $display("FAIL fields_%04h: got %h cnt=%0d want %h cnt=1", words[i], dut_outs, count, model_head());
            end
            if (i == 0) begin
                checks++;
                if ({out_valid, opcode, dest, src1, src2, imm_bit} !== {1'b1, 4'h1, 3'd1, 3'd2, 3'd3, 1'b0}) begin
                    errors++;
                    $display("FAIL add_reg: v=%b op=%h d=%0d s1=%0d s2=%0d imm=%b", out_valid, opcode, dest, src1, src2, imm_bit);
                end
            end
            if (i == 1) begin
                checks++;
                if ({imm_bit, imm5, sext5} !== {1'b1, 5'h1F, 16'hFFFF}) begin
                    errors++;
                    $display("FAIL add_imm: imm=%b imm5=%h sext5=%h want 1/1f/ffff", imm_bit, imm5, sext5);
                end
            end
            if (i == 2) begin
                checks++;
                if ({offset9, adj9} !== {9'h1FF, 16'hFFFE}) begin
                    errors++;
                    $display("FAIL br_off: off9=%h adj9=%h want 1ff/fffe", offset9, adj9);
                end
            end
            if (i == 3) begin
                checks++;
                if ({jsr_bit, offset11, adj11} !== {1'b1, 11'h7FE, 16'hFFFC}) begin
                    errors++;
                    $display("FAIL jsr_off: jsr=%b off11=%h adj11=%h want 1/7fe/fffc", jsr_bit, offset11, adj11);
                end
            end
            if (i == 4) begin
                checks++;
                if ({trapvect8, zext8x2} !== {8'h25, 16'h004A}) begin
                    errors++;
                    $display("FAIL trap: tv=%h zext=%h want 25/004a", trapvect8, zext8x2);
                end
            end
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || dut_outs !== '0) begin
                errors++;
                $display("FAIL fields_pop_%0d: out_valid=%b outs=%h want empty", i, out_valid, dut_outs);
            end
        end
    endtask

    task automatic test_fill();
        logic [15:0] pushed [5];
        for (int i = 0; i < 5; i++) begin
            pushed[i] = 16'($urandom);
            cycle(1'b1, pushed[i], 1'b0, 1'b0);
            checks++;
            if (count !== CW'(i < DEPTH ? i + 1 : DEPTH) || in_ready !== (i < DEPTH - 1)) begin
                errors++;
                $display("FAIL fill_%0d: count=%0d in_ready=%b", i, count, in_ready);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (dut_outs !== model_outs(1'b1, pushed[i])) begin
                errors++;
                $display("FAIL drain_order_%0d: got %h want %h", i, dut_outs, model_outs(1'b1, pushed[i]));
            end
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
        checks++;
        if (out_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL drain_empty: out_valid=%b count=%0d want 0/0", out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
            checks++;
            if (count !== CW'(2) || dut_outs !== model_head()) begin
                errors++;
                $display("FAIL b2b_%0d: count=%0d outs=%h want 2/%h", i, count, dut_outs, model_head());
            end
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 16'hABCD, 1'b1, 1'b1);
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || dut_outs !== '0) begin
            errors++;
            $display("FAIL flush: count=%0d out_valid=%b outs=%h want empty", count, out_valid, dut_outs);
        end
        cycle(1'b1, 16'h5A5A, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(1) || dut_outs !== model_outs(1'b1, 16'h5A5A)) begin
            errors++;
            $display("FAIL post_flush: count=%0d outs=%h want 1/%h", count, dut_outs, model_outs(1'b1, 16'h5A5A));
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1 || dut_outs !== '0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b count=%0d in_ready=%b want 0/0/1", out_valid, count, in_ready);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0),
                  $urandom_range(0, 15) == 0);
            checks++;
            if (dut_outs !== model_head() || count !== CW'(exp_q.size()) ||
                in_ready !== (exp_q.size() < DEPTH)) begin
                errors++;
                $display("FAIL random_%0d: outs=%h cnt=%0d rdy=%b want %h cnt=%0d", i, dut_outs, count,
                         in_ready, model_head(), exp_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fields();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
